// File: rtl/red_pitaya_dfilt_dac.sv
// DAC-side equalizer: FIR pre-emphasis, single-pole IIR and output gain with saturation.
// Coefficients are double-buffered and swapped in through a short flush of the filter path.
module red_pitaya_dfilt_dac #(
  parameter int unsigned FLUSH_LEN = 5
) (
  input  logic               dac_clk_i,
  input  logic               dac_rstn_i,
  input  logic signed [13:0] dac_dat_i,
  output logic signed [13:0] dac_dat_o,
  input  logic signed [17:0] cfg_bb_i,
  input  logic signed [17:0] cfg_aa_i,
  input  logic signed [17:0] cfg_kk_i,
  input  logic               cfg_we_i,
  input  logic               cfg_en_i,
  output logic               cfg_busy_o,
  output logic               sat_o,
  input  logic               sat_clr_i
);

  typedef enum logic [1:0] {ST_BYPASS, ST_RUN, ST_FLUSH} state_e;

  typedef struct packed {
    logic [17:0] aa;
    logic [17:0] bb;
    logic [17:0] kk;
  } coef_t;

  localparam coef_t      COEF_RST = '{aa: 18'h0_0000, bb: 18'h0_0000, kk: 18'h1_0000};
  localparam logic [2:0] CNT_LAST = 3'(FLUSH_LEN - 1);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               load_act;
  coef_t              shd_q, shd_d, act_q;
  logic               busy_q, sat_q, sat_d;

  logic signed [13:0] x1_q;
  logic signed [14:0] dif1_q, dif1_d;
  logic signed [15:0] w2_q, w2_d;
  logic signed [23:0] v3_q, v3_d;
  logic signed [17:0] g4_q, g4_d;
  logic signed [13:0] byp_q [4];
  logic signed [13:0] dat_q, dat_d;

  logic signed [17:0] aa_act, bb_act, kk_act;
  logic signed [16:0] bb_term;
  logic signed [17:0] s2_sum;
  logic signed [23:0] w2_sh;
  logic signed [24:0] aa_term;
  logic signed [25:0] s3_sum;
  logic signed [13:0] g4_sat;
  logic               clamp16, clamp24, clamp14;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_act = 1'b0;
    unique case (state_q)
      ST_BYPASS: begin
        if (cfg_en_i) begin
          state_d  = ST_FLUSH;
          cnt_d    = '0;
          load_act = 1'b1;
        end
      end
      ST_RUN: begin
        if (!cfg_en_i) begin
          state_d = ST_BYPASS;
        end else if (cfg_we_i) begin
          state_d  = ST_FLUSH;
          cnt_d    = '0;
          load_act = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (!cfg_en_i) begin
          state_d = ST_BYPASS;
        end else if (cfg_we_i) begin
          cnt_d    = '0;
          load_act = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = ST_BYPASS;
    endcase
  end

  // Active set loads from shd_d so a write in the entry cycle takes effect at once.
  always_comb begin
    shd_d = shd_q;
    if (cfg_we_i) shd_d = '{aa: cfg_aa_i, bb: cfg_bb_i, kk: cfg_kk_i};
  end

  assign aa_act = act_q.aa;
  assign bb_act = act_q.bb;
  assign kk_act = act_q.kk;

  assign dif1_d  = 15'(dac_dat_i) - 15'(x1_q);

  assign bb_term = 17'((33'(bb_act) * 33'(dif1_q)) >>> 16);
  assign s2_sum  = 18'(x1_q) + 18'(bb_term);
  assign clamp16 = (s2_sum[17:15] != 3'b000) && (s2_sum[17:15] != 3'b111);
  assign w2_d    = clamp16 ? (s2_sum[17] ? 16'sh8000 : 16'sh7FFF) : s2_sum[15:0];

  assign w2_sh   = {w2_q, 8'h00};
  assign aa_term = 25'((42'(aa_act) * 42'(v3_q)) >>> 17);
  assign s3_sum  = 26'(w2_sh) + 26'(aa_term);
  assign clamp24 = (s3_sum[25:23] != 3'b000) && (s3_sum[25:23] != 3'b111);
  assign v3_d    = load_act ? '0 :
                   clamp24  ? (s3_sum[25] ? 24'sh80_0000 : 24'sh7F_FFFF) : s3_sum[23:0];

  assign g4_d    = 18'((42'(kk_act) * 42'(v3_q)) >>> 24);
  assign clamp14 = (g4_q[17:13] != 5'b00000) && (g4_q[17:13] != 5'b11111);
  assign g4_sat  = clamp14 ? (g4_q[17] ? 14'sh2000 : 14'sh1FFF) : g4_q[13:0];

  assign dat_d   = (state_q == ST_RUN) ? g4_sat : byp_q[3];
  assign sat_d   = ((state_q == ST_RUN) && (clamp16 || clamp24 || clamp14)) || (sat_q && !sat_clr_i);

  // NOTE: all state updates use non-blocking assignments so stages shift in lockstep.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q <= ST_BYPASS;
      cnt_q   <= '0;
      shd_q   <= COEF_RST;
      act_q   <= COEF_RST;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
      x1_q    <= '0;
      dif1_q  <= '0;
      w2_q    <= '0;
      v3_q    <= '0;
      g4_q    <= '0;
      dat_q   <= '0;
      // NOTE: the bypass line is reset too, so the output reads 0 straight out of reset.
      for (int i = 0; i < 4; i++) byp_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shd_q   <= shd_d;
      if (load_act) act_q <= shd_d;
      busy_q  <= (state_d == ST_FLUSH);
      sat_q   <= sat_d;
      x1_q    <= dac_dat_i;
      dif1_q  <= dif1_d;
      w2_q    <= w2_d;
      v3_q    <= v3_d;
      g4_q    <= g4_d;
      dat_q   <= dat_d;
      byp_q[0] <= dac_dat_i;
      for (int i = 1; i < 4; i++) byp_q[i] <= byp_q[i-1];
    end
  end

  assign dac_dat_o  = dat_q;
  assign cfg_busy_o = busy_q;
  assign sat_o      = sat_q;

endmodule
